// File: rtl/timer_0_sequencer.sv
// Round-robin scheduler that time-shares the interval timer among NUM_REQ requesters.
// It programs a one-shot period over the timer's Avalon-MM slave port and reports completion or abort.
module timer_0_sequencer #(
  parameter int NUM_REQ = 2
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [NUM_REQ-1:0]      req_valid,
  input  logic [32*NUM_REQ-1:0]   req_ticks,
  input  logic [NUM_REQ-1:0]      cancel,
  output logic [NUM_REQ-1:0]      done,
  output logic                    done_aborted,
  output logic                    busy,
  output logic [2:0]              grant_id,
  output logic [3:0]              tmr_address,
  output logic                    tmr_chipselect,
  output logic                    tmr_write_n,
  output logic [15:0]             tmr_writedata,
  input  logic                    tmr_irq
);

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  localparam logic [3:0]  ADDR_STATUS = 4'd0;
  localparam logic [3:0]  ADDR_CTRL   = 4'd1;
  localparam logic [15:0] CTRL_STOP   = 16'h0008;
  localparam logic [15:0] CTRL_START  = 16'h0005;

  typedef enum logic [3:0] {
    S_IDLE, S_STOP, S_P0, S_P1, S_P2, S_P3, S_CLR, S_START,
    S_WAIT, S_ACK, S_ASTOP, S_ACLR, S_DONE
  } state_t;

  state_t            state_q, state_d;
  logic [IW-1:0]     ptr_q;
  logic [IW-1:0]     grant_q;
  logic [31:0]       ticks_q;
  logic [31:0]       period;
  logic [IW-1:0]     pick;
  logic              found;
  logic [NUM_REQ-1:0] grant_onehot;

  // Search starts at the round-robin pointer and wraps, so the first hit is the fair winner.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      int idx;
      idx = (int'(ptr_q) + k) % NUM_REQ;
      if (!found && req_valid[idx]) begin
        found = 1'b1;
        pick  = IW'(idx);
      end
    end
  end

  always_comb begin
    grant_onehot          = '0;
    grant_onehot[grant_q] = 1'b1;
  end

  // A zero request behaves like one tick, which programs a period of zero.
  assign period   = (ticks_q == 32'd0) ? 32'd0 : ticks_q - 32'd1;
  assign grant_id = 3'(grant_q);

  // NOTE: every signal written here gets a default first, so no path can infer a latch.
  always_comb begin
    state_d        = state_q;
    tmr_chipselect = 1'b0;
    tmr_write_n    = 1'b1;
    tmr_address    = '0;
    tmr_writedata  = '0;
    case (state_q)
      S_IDLE:  if (found) state_d = S_STOP;
      S_STOP: begin
        tmr_chipselect = 1'b1; tmr_write_n = 1'b0;
        tmr_address = ADDR_CTRL; tmr_writedata = CTRL_STOP;
        state_d = S_P0;
      end
      S_P0: begin
        tmr_chipselect = 1'b1; tmr_write_n = 1'b0;
        tmr_address = 4'd2; tmr_writedata = period[15:0];
        state_d = S_P1;
      end
      S_P1: begin
        tmr_chipselect = 1'b1; tmr_write_n = 1'b0;
        tmr_address = 4'd3; tmr_writedata = period[31:16];
        state_d = S_P2;
      end
      S_P2: begin
        tmr_chipselect = 1'b1; tmr_write_n = 1'b0;
        tmr_address = 4'd4;
        state_d = S_P3;
      end
      S_P3: begin
        tmr_chipselect = 1'b1; tmr_write_n = 1'b0;
        tmr_address = 4'd5;
        state_d = S_CLR;
      end
      S_CLR: begin
        tmr_chipselect = 1'b1; tmr_write_n = 1'b0;
        tmr_address = ADDR_STATUS;
        state_d = S_START;
      end
      S_START: begin
        tmr_chipselect = 1'b1; tmr_write_n = 1'b0;
        tmr_address = ADDR_CTRL; tmr_writedata = CTRL_START;
        state_d = S_WAIT;
      end
      // Expiry wins over a simultaneous cancel or request drop.
      S_WAIT: begin
        if (tmr_irq)                                   state_d = S_ACK;
        else if (cancel[grant_q] || !req_valid[grant_q]) state_d = S_ASTOP;
      end
      S_ACK: begin
        tmr_chipselect = 1'b1; tmr_write_n = 1'b0;
        tmr_address = ADDR_STATUS;
        state_d = S_DONE;
      end
      S_ASTOP: begin
        tmr_chipselect = 1'b1; tmr_write_n = 1'b0;
        tmr_address = ADDR_CTRL; tmr_writedata = CTRL_STOP;
        state_d = S_ACLR;
      end
      S_ACLR: begin
        tmr_chipselect = 1'b1; tmr_write_n = 1'b0;
        tmr_address = ADDR_STATUS;
        state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= S_IDLE;
      ptr_q        <= '0;
      grant_q      <= '0;
      ticks_q      <= '0;
      busy         <= 1'b0;
      done         <= '0;
      done_aborted <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == S_IDLE && found) begin
        grant_q <= pick;
        ptr_q   <= IW'((int'(pick) + 1) % NUM_REQ);
        ticks_q <= req_ticks[32*int'(pick) +: 32];
      end
      busy         <= (state_d != S_IDLE);
      done         <= (state_d == S_DONE) ? grant_onehot : '0;
      done_aborted <= (state_q == S_ACLR);
    end
  end

endmodule

// File: doc/timer_0_sequencer.md
# timer_0_sequencer

Hardware scheduler that shares the single system interval timer among `NUM_REQ` hardware requesters. It arbitrates requests round-robin and programs the timer through its 16-bit Avalon-MM slave port: stop, period, status clear, start in one-shot mode with interrupt enabled. It then waits for the timer IRQ, acknowledges it, and returns a completion pulse to the winning requester. It sits beside the Nios II on the same timer slave port, behind the interconnect, and owns the timer whenever `busy` is high.

## Interface
- `NUM_REQ`, default 2: number of requesters (1..8).
- `clk`  in  1  system clock.
- `reset_n`  in  1  asynchronous, active-low reset.
- `req_valid`  in  NUM_REQ  level request, held until the matching `done` bit.
- `req_ticks`  in  32*NUM_REQ  requested delay in clocks; requester i uses bits [32i+31:32i]; held stable while `req_valid[i]` is high.
- `cancel`  in  NUM_REQ  level abort request for the granted requester.
- `done`  out  NUM_REQ  one-cycle completion pulse to the granted requester.
- `done_aborted`  out  1  qualifies `done`: 1 = cancelled, 0 = timed out.
- `busy`  out  1  high from grant until the `done` cycle, inclusive.
- `grant_id`  out  3  index of the current or last granted requester.
- `tmr_address`  out  4  timer slave address.
- `tmr_chipselect`  out  1  timer slave chip select.
- `tmr_write_n`  out  1  timer slave write strobe, active low.
- `tmr_writedata`  out  16  timer slave write data.
- `tmr_irq`  in  1  timer interrupt.

## Operation
- Timer register map, word addresses:
  - 0 = status; any write clears the timeout flag.
  - 1 = control: bit0 ITO, bit1 CONT, bit2 START, bit3 STOP.
  - 2..5 = period halfwords, low first.
- All timer accesses are single-cycle writes with no wait state: `tmr_chipselect=1`, `tmr_write_n=0` for exactly one cycle per state that writes. Reads are never issued.
- Reset values: all outputs 0 except `tmr_write_n=1`. The round-robin pointer is 0 and the state is IDLE.
- IDLE: if any `req_valid` is set, grant the first set bit at or after the pointer (wrapping), latch its ticks, and set `busy` and `grant_id`. The pointer becomes grant+1 mod NUM_REQ.
- Programming states, one write each, in this order:
  - STOP: address 1, data 0x0008.
  - P0: address 2, data (T-1)[15:0].
  - P1: address 3, data (T-1)[31:16].
  - P2: address 4, data 0.
  - P3: address 5, data 0.
  - CLR: address 0, data 0.
  - START: address 1, data 0x0005 (START, ITO, one-shot).
- Tick arithmetic: T = latched ticks. T=0 is treated as 1, so the period written is 0. Subtraction is 32-bit unsigned.
- WAIT: no bus activity. Transitions, in priority order:
  - `tmr_irq=1` -> ACK.
  - `cancel[g]=1` or `req_valid[g]=0` -> ASTOP.
- ACK: address 0, data 0 (clears the IRQ) -> DONE with aborted=0.
- ASTOP: address 1, data 0x0008 -> ACLR.
- ACLR: address 0, data 0 -> DONE with aborted=1.
- DONE: pulse `done[g]`, drive `done_aborted`, deassert `busy` next cycle -> IDLE. No new grant is made in the DONE cycle.
- Cancel or request drop during STOP..START is ignored until WAIT, where it is acted on immediately.
- `tmr_irq` outside WAIT is ignored.
- Reset mid-operation returns to IDLE with reset values. The timer is not stopped; the next grant's STOP write does that.

## Timing
- Request to first timer write (STOP): 2 cycles (IDLE grant cycle, then STOP).
- Programming occupies 7 consecutive write cycles, STOP..START; `tmr_chipselect` is high for all 7 back-to-back.
- If WAIT samples `tmr_irq` high in cycle t: ACK write in t+1, `done` in t+2.
- Cancel sampled in WAIT in cycle t: ASTOP in t+1, ACLR in t+2, `done` with `done_aborted=1` in t+3.
- Minimum request-to-request turnaround for back-to-back grants: DONE, IDLE, STOP (new grant visible in the IDLE cycle).
- `done`, `done_aborted` and `busy` are registered outputs.

## Test plan
- Single request: `req_valid[0]=1`, ticks=100, simple timer model.
  - Writes observed: (1,0x0008), (2,0x0063), (3,0), (4,0), (5,0), (0,0), (1,0x0005), on consecutive cycles.
  - `done[0]` arrives 2 cycles after `tmr_irq` rises; `done_aborted=0`.
- Contention: `req_valid=2'b11` from reset.
  - Requester 0 is served first, then requester 1; pointer wrap is checked.
  - Requester 0 re-requesting during requester 1's service is served after it.
- Cancel: grant requester 1, assert `cancel[1]` during P1 and hold.
  - No reaction until WAIT.
  - Then writes (1,0x0008), (0,0) follow, and `done[1]` with `done_aborted=1`.
- IRQ versus cancel: `tmr_irq` and `cancel[0]` both asserted in the same WAIT cycle -> ACK path taken, `done_aborted=0`.
- Boundaries:
  - ticks=0 -> P0 and P1 data are 0.
  - ticks=0x0001_0000 -> P0=0xFFFF, P1=0x0000.
- Reset: assert `reset_n=0` during WAIT -> all outputs return to reset values immediately.
  - After release, a pending request is re-granted starting from pointer 0.
